// File: rtl/me_pkg.sv
// Shared widths, partition counts and state type for the integer-pel SAD minimum selector.
package me_pkg;

  localparam int unsigned SAD_W16x16 = 16;
  localparam int unsigned SAD_W16x32 = 17;
  localparam int unsigned SAD_W32x16 = 17;
  localparam int unsigned SAD_W32x32 = 18;
  localparam int unsigned MVX_W      = 6;
  localparam int unsigned MVY_W      = 8;
  localparam int unsigned MV_W       = 14;

  localparam int unsigned N_16x16 = 4;
  localparam int unsigned N_16x32 = 2;
  localparam int unsigned N_32x16 = 2;
  localparam int unsigned N_32x32 = 1;
  localparam int unsigned N_PART  = N_16x16 + N_16x32 + N_32x16 + N_32x32;

  typedef enum logic {IDLE, SEARCH} state_e;

  // Partition order: 16x16 lanes, then 16x32, then 32x16, then 32x32.
  function automatic int unsigned part_sad_w(input int unsigned idx);
    if (idx < N_16x16) return SAD_W16x16;
    else if (idx < N_16x16 + N_16x32) return SAD_W16x32;
    else if (idx < N_16x16 + N_16x32 + N_32x16) return SAD_W32x16;
    else return SAD_W32x32;
  endfunction

endpackage

// File: rtl/sad_min_cell.sv
// Running minimum SAD/MV for one partition. With SAD_MV_COST_EN defined the
// comparison uses a saturated SAD + LAMBDA*|mv| cost while the raw SAD is reported.
module sad_min_cell
  import me_pkg::*;
#(
  parameter int unsigned SAD_W = 16
`ifdef SAD_MV_COST_EN
  ,
  parameter int unsigned LAMBDA = 4
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [SAD_W-1:0] i_sad,
  input  logic [MV_W-1:0]  i_mv,
  output logic [SAD_W-1:0] o_best_sad,
  output logic [MV_W-1:0]  o_best_mv
);

  localparam logic [SAD_W-1:0] SadMax = '1;

  logic [SAD_W-1:0] r_best_sad;
  logic [MV_W-1:0]  r_best_mv;
  logic             w_win;

`ifdef SAD_MV_COST_EN
  logic [SAD_W-1:0]        r_best_cost;
  logic [SAD_W-1:0]        w_cost;
  logic signed [31:0]      w_sx;
  logic signed [31:0]      w_sy;
  logic [31:0]             w_mag;
  logic [31:0]             w_cost_wide;

  always_comb begin
    w_sx        = {{(32-MVX_W){i_mv[MVX_W-1]}}, i_mv[MVX_W-1:0]};
    w_sy        = {{(32-MVY_W){i_mv[MV_W-1]}}, i_mv[MV_W-1:MVX_W]};
    w_mag       = 32'((w_sx < 0) ? -w_sx : w_sx) + 32'((w_sy < 0) ? -w_sy : w_sy);
    w_cost_wide = {{(32-SAD_W){1'b0}}, i_sad} + LAMBDA * w_mag;
    w_cost      = (w_cost_wide > 32'(SadMax)) ? SadMax : w_cost_wide[SAD_W-1:0];
    w_win       = (w_cost < r_best_cost);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_best_cost <= SadMax;
    end else if (i_clear) begin
      r_best_cost <= SadMax;
    end else if (i_valid && w_win) begin
      r_best_cost <= w_cost;
    end
  end
`else
  assign w_win = (i_sad < r_best_sad);
`endif

  // Strict less-than keeps the earliest point on ties.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_best_sad <= SadMax;
      r_best_mv  <= '0;
    end else if (i_clear) begin
      r_best_sad <= SadMax;
    end else if (i_valid && w_win) begin
      r_best_sad <= i_sad;
      r_best_mv  <= i_mv;
    end
  end

  assign o_best_sad = r_best_sad;
  assign o_best_mv  = r_best_mv;

endmodule

// File: rtl/sad_best_mv_selector.sv
// Tracks the best SAD/MV of the nine large partitions over one search and pulses
// result_valid when done. Optional MV-cost comparison via SAD_MV_COST_EN.
module sad_best_mv_selector
  import me_pkg::*;
#(
  parameter int unsigned COL_CENTER = 16,
  parameter int unsigned ROW_CENTER = 64,
  parameter int unsigned LAMBDA     = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_search_start,
  input  logic        i_sad_valid,
  input  logic        i_sad_last,
  input  logic [4:0]  i_search_column_count,
  input  logic [6:0]  i_search_row_count,
  input  logic [63:0] i_sad16x16,
  input  logic [33:0] i_sad16x32,
  input  logic [33:0] i_sad32x16,
  input  logic [17:0] i_sad32x32,
  output logic        o_busy,
  output logic        o_result_valid,
  output logic [63:0] o_best_sad16x16,
  output logic [33:0] o_best_sad16x32,
  output logic [33:0] o_best_sad32x16,
  output logic [17:0] o_best_sad32x32,
  output logic [55:0] o_best_mv16x16,
  output logic [27:0] o_best_mv16x32,
  output logic [27:0] o_best_mv32x16,
  output logic [13:0] o_best_mv32x32
);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_result_valid;
  logic             w_result_valid_next;
  logic             w_clear;
  logic             w_update;
  logic             w_busy;
  logic [MVX_W-1:0] w_mvx;
  logic [MVY_W-1:0] w_mvy;
  logic [MV_W-1:0]  w_mv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:   if (i_search_start) w_state_next = SEARCH;
      SEARCH: begin
        if (i_search_start) w_state_next = SEARCH;
        else if (i_sad_valid && i_sad_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A start in the same cycle as a point discards that point.
  always_comb begin
    w_busy              = (r_state == SEARCH);
    w_clear             = i_search_start;
    w_update            = (r_state == SEARCH) && i_sad_valid && !i_search_start;
    w_result_valid_next = w_update && i_sad_last;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= w_result_valid_next;
    end
  end

  assign o_busy         = w_busy;
  assign o_result_valid = r_result_valid;

  // Wrapping subtraction at field width gives the two's complement MV directly.
  assign w_mvx = {1'b0, i_search_column_count} - MVX_W'(COL_CENTER);
  assign w_mvy = {1'b0, i_search_row_count} - MVY_W'(ROW_CENTER);
  assign w_mv  = {w_mvy, w_mvx};

`ifndef SAD_MV_COST_EN
  logic w_unused_lambda;
  assign w_unused_lambda = (LAMBDA != 0);
`endif

  genvar g;
  for (g = 0; g < N_PART; g++) begin : g_cell
    localparam int unsigned SadW = part_sad_w(g);

    logic [SadW-1:0] w_sad;
    logic [SadW-1:0] w_best_sad;
    logic [MV_W-1:0] w_best_mv;

    if (g < N_16x16) begin : g_16x16
      assign w_sad = i_sad16x16[g*SAD_W16x16 +: SAD_W16x16];
      assign o_best_sad16x16[g*SAD_W16x16 +: SAD_W16x16] = w_best_sad;
      assign o_best_mv16x16[g*MV_W +: MV_W] = w_best_mv;
    end else if (g < N_16x16 + N_16x32) begin : g_16x32
      localparam int unsigned Lane = g - N_16x16;
      assign w_sad = i_sad16x32[Lane*SAD_W16x32 +: SAD_W16x32];
      assign o_best_sad16x32[Lane*SAD_W16x32 +: SAD_W16x32] = w_best_sad;
      assign o_best_mv16x32[Lane*MV_W +: MV_W] = w_best_mv;
    end else if (g < N_16x16 + N_16x32 + N_32x16) begin : g_32x16
      localparam int unsigned Lane = g - N_16x16 - N_16x32;
      assign w_sad = i_sad32x16[Lane*SAD_W32x16 +: SAD_W32x16];
      assign o_best_sad32x16[Lane*SAD_W32x16 +: SAD_W32x16] = w_best_sad;
      assign o_best_mv32x16[Lane*MV_W +: MV_W] = w_best_mv;
    end else begin : g_32x32
      assign w_sad           = i_sad32x32;
      assign o_best_sad32x32 = w_best_sad;
      assign o_best_mv32x32  = w_best_mv;
    end

    sad_min_cell #(
      .SAD_W  (SadW)
`ifdef SAD_MV_COST_EN
      ,
      .LAMBDA (LAMBDA)
`endif
    ) u_cell (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clear    (w_clear),
      .i_valid    (w_update),
      .i_sad      (w_sad),
      .i_mv       (w_mv),
      .o_best_sad (w_best_sad),
      .o_best_mv  (w_best_mv)
    );
  end

endmodule

// File: tb/tb_sad_best_mv_selector.sv
// Directed self-checking bench for sad_best_mv_selector (default and SAD_MV_COST_EN builds).
module tb_sad_best_mv_selector;

  logic        clk;
  logic        rst_n;
  logic        search_start;
  logic        sad_valid;
  logic        sad_last;
  logic [4:0]  col;
  logic [6:0]  row;
  logic [63:0] sad16x16;
  logic [33:0] sad16x32;
  logic [33:0] sad32x16;
  logic [17:0] sad32x32;
  logic        busy;
  logic        result_valid;
  logic [63:0] best_sad16x16;
  logic [33:0] best_sad16x32;
  logic [33:0] best_sad32x16;
  logic [17:0] best_sad32x32;
  logic [55:0] best_mv16x16;
  logic [27:0] best_mv16x32;
  logic [27:0] best_mv32x16;
  logic [13:0] best_mv32x32;

  int n_checks;
  int n_errors;
  int pulse_cnt;

  sad_best_mv_selector u_dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_search_start        (search_start),
    .i_sad_valid           (sad_valid),
    .i_sad_last            (sad_last),
    .i_search_column_count (col),
    .i_search_row_count    (row),
    .i_sad16x16            (sad16x16),
    .i_sad16x32            (sad16x32),
    .i_sad32x16            (sad32x16),
    .i_sad32x32            (sad32x32),
    .o_busy                (busy),
    .o_result_valid        (result_valid),
    .o_best_sad16x16       (best_sad16x16),
    .o_best_sad16x32       (best_sad16x32),
    .o_best_sad32x16       (best_sad32x16),
    .o_best_sad32x32       (best_sad32x32),
    .o_best_mv16x16        (best_mv16x16),
    .o_best_mv16x32        (best_mv16x32),
    .o_best_mv32x16        (best_mv32x16),
    .o_best_mv32x32        (best_mv32x32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (result_valid === 1'b1) pulse_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_search();
    search_start = 1'b1;
    step();
    search_start = 1'b0;
  endtask

  task automatic drive_pt(input logic [4:0] c, input logic [6:0] r, input logic [63:0] s16,
                          input logic [33:0] s1632, input logic [33:0] s3216,
                          input logic [17:0] s32, input logic last);
    col = c; row = r; sad16x16 = s16; sad16x32 = s1632; sad32x16 = s3216; sad32x32 = s32;
    sad_valid = 1'b1; sad_last = last;
    step();
    sad_valid = 1'b0; sad_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; search_start = 1'b0; sad_valid = 1'b0; sad_last = 1'b0;
    col = '0; row = '0; sad16x16 = '0; sad16x32 = '0; sad32x16 = '0; sad32x32 = '0;
    repeat (2) step();
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_result_valid: got %b want 0", result_valid);
    end
    n_checks++;
    if (best_sad16x16 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_errors++; $display("FAIL reset_sad16x16: got %h want all-ones", best_sad16x16);
    end
    n_checks++;
    if (best_sad32x32 !== 18'h3FFFF || best_sad16x32 !== 34'h3_FFFF_FFFF) begin
      n_errors++; $display("FAIL reset_sad32: got %h/%h want all-ones", best_sad32x32,
                           best_sad16x32);
    end
    n_checks++;
    if (best_mv16x16 !== 56'd0 || best_mv32x32 !== 14'd0) begin
      n_errors++; $display("FAIL reset_mv: got %h/%h want 0", best_mv16x16, best_mv32x32);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_all_const();
    start_search();
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL const_busy: got %b want 1", busy); end
    for (int i = 0; i < 128; i++) begin
      drive_pt(5'(i % 32), 7'(i / 32), {4{16'd100}}, {2{17'd100}}, {2{17'd100}}, 18'd100,
               i == 127);
      if (i == 126) begin
        n_checks++;
        if (result_valid !== 1'b0) begin
          n_errors++; $display("FAIL const_early_pulse: got %b want 0", result_valid);
        end
      end
    end
    n_checks++;
    if (result_valid !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL const_pulse: got rv=%b busy=%b want rv=1 busy=0",
                           result_valid, busy);
    end
    n_checks++;
    if (best_sad16x16 !== {4{16'd100}} || best_sad16x32 !== {2{17'd100}} ||
        best_sad32x16 !== {2{17'd100}} || best_sad32x32 !== 18'd100) begin
      n_errors++; $display("FAIL const_sad: got %h %h %h %h want all 100", best_sad16x16,
                           best_sad16x32, best_sad32x16, best_sad32x32);
    end
    n_checks++;
    if (best_mv16x16 !== {4{8'hC0, 6'h30}} || best_mv16x32 !== {2{8'hC0, 6'h30}} ||
        best_mv32x16 !== {2{8'hC0, 6'h30}} || best_mv32x32 !== {8'hC0, 6'h30}) begin
      n_errors++; $display("FAIL const_mv: got %h %h %h %h want point0 (3030)", best_mv16x16,
                           best_mv16x32, best_mv32x16, best_mv32x32);
    end
    step();
    n_checks++;
    if (result_valid !== 1'b0 || best_sad32x32 !== 18'd100) begin
      n_errors++; $display("FAIL const_pulse_width: got rv=%b sad=%0d want rv=0 sad=100",
                           result_valid, best_sad32x32);
    end
  endtask

  task automatic test_single_min();
    start_search();
    for (int i = 0; i < 64; i++) begin
      logic [4:0] c;
      logic [6:0] r;
      c = 5'(i % 32);
      r = 7'(69 + i / 32);
      drive_pt(c, r, {4{16'd200}}, {2{17'd200}}, {2{17'd200}},
               (c == 5'd20 && r == 7'd70) ? 18'd20 : 18'd500, i == 63);
    end
    n_checks++;
    if (best_sad32x32 !== 18'd20 || best_mv32x32 !== {8'h06, 6'h04}) begin
      n_errors++; $display("FAIL min32x32: got sad=%0d mv=%h want sad=20 mv=%h", best_sad32x32,
                           best_mv32x32, {8'h06, 6'h04});
    end
    n_checks++;
    if (best_sad16x16 !== {4{16'd200}} || best_mv16x16 !== {4{8'h05, 6'h30}} ||
        best_sad32x16 !== {2{17'd200}}) begin
      n_errors++; $display("FAIL min_others: got %h mv=%h want 200s mv=0170", best_sad16x16,
                           best_mv16x16);
    end
  endtask

  task automatic test_tie();
    start_search();
    for (int i = 0; i < 12; i++) begin
      logic [15:0] l0;
      logic [15:0] l1;
      l0 = (i == 2 || i == 8) ? 16'd50 : 16'd60;
      l1 = 16'(300 - i);
      drive_pt(5'(i), 7'd64, {16'd300, 16'd300, l1, l0}, {2{17'd300}}, {2{17'd300}}, 18'd300,
               i == 11);
    end
    n_checks++;
    if (best_sad16x16[15:0] !== 16'd50 || best_mv16x16[13:0] !== {8'h00, 6'h32}) begin
      n_errors++; $display("FAIL tie_lane0: got sad=%0d mv=%h want sad=50 mv=%h",
                           best_sad16x16[15:0], best_mv16x16[13:0], {8'h00, 6'h32});
    end
    n_checks++;
    if (best_sad16x16[31:16] !== 16'd289 || best_mv16x16[27:14] !== {8'h00, 6'h3B}) begin
      n_errors++; $display("FAIL tie_lane1_dec: got sad=%0d mv=%h want sad=289 mv=%h",
                           best_sad16x16[31:16], best_mv16x16[27:14], {8'h00, 6'h3B});
    end
    n_checks++;
    if (best_mv16x16[41:28] !== {8'h00, 6'h30}) begin
      n_errors++; $display("FAIL tie_lane2_first: got mv=%h want %h", best_mv16x16[41:28],
                           {8'h00, 6'h30});
    end
  endtask

  task automatic test_abort();
    step();
    pulse_cnt = 0;
    start_search();
    for (int i = 0; i < 40; i++) begin
      drive_pt(5'(i % 32), 7'(i / 32), {4{16'd100}}, {2{17'd100}}, {2{17'd100}},
               (i == 10) ? 18'd5 : 18'd100, 1'b0);
    end
    search_start = 1'b1;
    drive_pt(5'd8, 7'd1, {4{16'd1}}, {2{17'd1}}, {2{17'd1}}, 18'd1, 1'b1);
    search_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      n_errors++; $display("FAIL abort_state: got busy=%b rv=%b want busy=1 rv=0", busy,
                           result_valid);
    end
    for (int c = 0; c < 32; c++) begin
      drive_pt(5'(c), 7'd2, {4{16'd100}}, {2{17'd100}}, {2{17'd100}},
               (c == 5) ? 18'd30 : 18'd100, c == 31);
    end
    n_checks++;
    if (best_sad32x32 !== 18'd30 || best_mv32x32 !== {8'hC2, 6'h35}) begin
      n_errors++; $display("FAIL abort_result: got sad=%0d mv=%h want sad=30 mv=%h",
                           best_sad32x32, best_mv32x32, {8'hC2, 6'h35});
    end
    step();
    step();
    n_checks++;
    if (pulse_cnt !== 1) begin
      n_errors++; $display("FAIL abort_pulses: got %0d want 1", pulse_cnt);
    end
  endtask

  task automatic test_reset_mid();
    pulse_cnt = 0;
    start_search();
    for (int i = 0; i < 5; i++) begin
      drive_pt(5'(i), 7'd0, {4{16'd7}}, {2{17'd7}}, {2{17'd7}}, 18'd7, 1'b0);
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b0 || best_sad32x32 !== 18'h3FFFF || best_mv16x16 !== 56'd0) begin
      n_errors++; $display("FAIL rstmid_async: got busy=%b sad=%h mv=%h want 0/3ffff/0", busy,
                           best_sad32x32, best_mv16x16);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_pt(5'(i), 7'd64, 64'd0, 34'd0, 34'd0, 18'd0, 1'b1);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || best_sad16x16 !== 64'hFFFF_FFFF_FFFF_FFFF ||
        best_sad32x16 !== 34'h3_FFFF_FFFF || best_sad32x32 !== 18'h3FFFF) begin
      n_errors++; $display("FAIL rstmid_idle_sad: got busy=%b %h %h %h want 0/all-ones", busy,
                           best_sad16x16, best_sad32x16, best_sad32x32);
    end
    n_checks++;
    if (best_mv32x32 !== 14'd0 || best_mv16x32 !== 28'd0 || pulse_cnt !== 0) begin
      n_errors++; $display("FAIL rstmid_idle_mv: got mv=%h/%h pulses=%0d want 0/0/0",
                           best_mv32x32, best_mv16x32, pulse_cnt);
    end
  endtask

  task automatic test_cost();
    logic [17:0] exp_sad;
    logic [13:0] exp_mv;
`ifdef SAD_MV_COST_EN
    exp_sad = 18'd100;
    exp_mv  = {8'h00, 6'h00};
`else
    exp_sad = 18'd90;
    exp_mv  = {8'h03, 6'h05};
`endif
    start_search();
    drive_pt(5'd16, 7'd64, {4{16'd100}}, {2{17'd100}}, {2{17'd100}}, 18'd100, 1'b0);
    drive_pt(5'd21, 7'd67, {4{16'd90}}, {2{17'd90}}, {2{17'd90}}, 18'd90, 1'b1);
    n_checks++;
    if (best_sad32x32 !== exp_sad || best_mv32x32 !== exp_mv) begin
      n_errors++; $display("FAIL cost_32x32: got sad=%0d mv=%h want sad=%0d mv=%h",
                           best_sad32x32, best_mv32x32, exp_sad, exp_mv);
    end
    n_checks++;
    if (best_sad16x16[15:0] !== exp_sad[15:0] || best_mv16x16[13:0] !== exp_mv) begin
      n_errors++; $display("FAIL cost_16x16: got sad=%0d mv=%h want sad=%0d mv=%h",
                           best_sad16x16[15:0], best_mv16x16[13:0], exp_sad, exp_mv);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    pulse_cnt = 0;
    test_reset();
`ifndef SAD_MV_COST_EN
    test_all_const();
    test_single_min();
    test_tie();
    test_abort();
`endif
    test_reset_mid();
    test_cost();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sad_best_mv_selector.md
Name: sad_best_mv_selector

Overview:
- Consumer of the integer-pel search engine's SAD stream for the large partitions: 16x16 (x4), 16x32 (x2), 32x16 (x2) and 32x32 (x1), nine candidates per search point.
- Each cycle it takes one search point's SADs plus its column/row counters, and keeps the running minimum SAD and matching motion vector per partition.
- At the end of a search it presents the best SAD/MV set to the mode-decision stage with a one-cycle result pulse.

Parameters:
- COL_CENTER, 16, column count that maps to mvx = 0.
- ROW_CENTER, 64, row count that maps to mvy = 0.
- LAMBDA, 4, MV-cost weight; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- search_start  in  1  pulse; begins a new search and clears the minima.
- sad_valid  in  1  SAD buses and counters are valid this cycle.
- sad_last  in  1  qualifies the final search point; meaningful only when sad_valid=1.
- search_column_count  in  5  column index of the current search point.
- search_row_count  in  7  row index of the current search point.
- SAD16x16  in  64  4x16b fields; partition 0 at LSB; raster order.
- SAD16x32  in  34  2x17b fields; left partition at LSB.
- SAD32x16  in  34  2x17b fields; top partition at LSB.
- SAD32x32  in  18  1x18b.
- busy  out  1  high while in SEARCH.
- result_valid  out  1  one-cycle pulse when the best set is final.
- best_sad16x16  out  64  same packing as SAD16x16.
- best_sad16x32  out  34  same packing as SAD16x32.
- best_sad32x16  out  34  same packing as SAD32x16.
- best_sad32x32  out  18  same packing as SAD32x32.
- best_mv16x16  out  56  4x14b fields, each {mvy[7:0], mvx[5:0]}, two's complement.
- best_mv16x32  out  28  2x14b, same field format.
- best_mv32x16  out  28  2x14b, same field format.
- best_mv32x32  out  14  1x14b, same field format.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0; result_valid=0.
  - all best_sad fields = all-ones; all best_mv fields = 0.
- MV computation: mvx = column - COL_CENTER (6b signed); mvy = row - ROW_CENTER (8b signed).
  - Subtraction is done at 6b/8b width and wraps; with defaults this covers mvx -16..15 and mvy -64..63.
- IDLE:
  - search_start -> SEARCH next cycle; every best_sad field is set to all-ones on the same edge.
  - sad_valid is ignored.
  - best outputs hold the previous result.
- SEARCH, on sad_valid=1:
  - Each of the 9 partitions compares independently.
  - Update SAD and MV only if the new SAD is strictly less than the stored one; ties keep the earlier point (first in scan order wins).
  - The first valid point after start always wins, because stored = all-ones, except a SAD exactly equal to all-ones.
- SEARCH, on sad_valid=1 and sad_last=1:
  - That final point is compared normally.
  - Next cycle: state=IDLE, busy=0, result_valid=1 for exactly one cycle.
  - Outputs are stable from that pulse until the next search_start.
- SEARCH, on sad_last without sad_valid: ignored.
- search_start during SEARCH: aborts; minima are re-cleared and the state stays in SEARCH. No result_valid is produced for the aborted search.
- search_start in the same cycle as a valid sad_last:
  - Start wins: the last point is discarded, minima are cleared, and no pulse is produced.
- Latency: registered outputs update on the edge that samples sad_valid; result_valid follows one cycle after the last point.
- Reset mid-search: immediate return to reset values; no pulse.

Optional Feature:
- Macro: SAD_MV_COST_EN.
- Defined:
  - Comparison uses cost = SAD + LAMBDA*(|mvx|+|mvy|), saturated to that partition's SAD field width.
  - The module stores and compares the cost per partition, but best_sad still reports the winner's raw SAD.
  - Tie rule is unchanged.
- Undefined: comparison uses raw SAD only; no cost registers or adders are built.

Decomposition:
- Shared package me_pkg:
  - field widths: SAD_W16x16=16, SAD_W16x32=17, SAD_W32x32=18, MVX_W=6, MVY_W=8, MV_W=14;
  - state enum {IDLE, SEARCH};
  - partition counts.
- Sub-module sad_min_cell, parameterised by SAD width:
  - clear, valid, sad, mv inputs; best_sad and best_mv outputs;
  - optional cost path.
  - Instantiated 9 times by a generate loop.

Test Plan:
1. All SADs constant 100 for 128 points (column 0..31 by row, from row 0) -> every best_sad=100; every best_mv = point 0: mvx=-16 (6'h30), mvy=-64 (8'hC0); result_valid high exactly one cycle after the sad_last point.
2. SAD32x32 = 500 everywhere except 20 at column 20, row 70 -> best_sad32x32=20, best_mv32x32 mvx=+4, mvy=+6; other partitions unaffected.
3. Tie: SAD16x16[0] = 50 at the 3rd and 9th points, 60 elsewhere -> the MV of the 3rd point is retained.
4. Abort: search_start asserted at point 40 after a minimum of 5 seen at point 10, followed by a full search with a minimum of 30 -> result shows 30, not 5; only one result_valid pulse.
5. rst_n deasserted mid-search, then sad_valid pulses in IDLE with SAD 0 -> outputs stay at reset values (all-ones/0), busy=0, no result_valid.
6. With SAD_MV_COST_EN defined and LAMBDA=4: SAD 100 at MV(0,0) vs SAD 90 at MV(+5,+3) -> cost 100 vs 122, so MV(0,0) wins with best_sad=100; with the macro undefined, MV(+5,+3) wins with 90.
